// File: rtl/fetch_queue_unit_pkg.sv
// fetch_queue_unit_pkg: shared types, opcodes and immediate decoders for the fetch front-end
package fetch_queue_unit_pkg;

    localparam int WORD_RANGE = 32;
    localparam logic [6:0] JAL_OPCODE = 7'b1101111;
    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

    typedef logic [WORD_RANGE-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        word_t inst;
        word_t pc;
        word_t predict_pc;
    } iq_entry_t;

    function automatic word_t imm_j(word_t inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic word_t imm_b(word_t inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue_unit_inst_queue.sv
// fetch_inst_queue: flushable FIFO between fetch and issue
module fetch_inst_queue #(
    parameter int DEPTH_W = 3,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [DEPTH_W:0]  count
);

    localparam logic [DEPTH_W:0] ONE = (DEPTH_W+1)'(1);

    logic [DATA_W-1:0] slots [2**DEPTH_W];
    logic [DEPTH_W:0] wr_ptr;
    logic [DEPTH_W:0] rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full = count[DEPTH_W];
    assign empty = count == '0;
    assign head = slots[rd_ptr[DEPTH_W-1:0]];

    // pointers wrap with an extra bit so full and empty are distinguishable; flush rewinds both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop) rd_ptr <= rd_ptr + ONE;
        end
    end

    // entry storage, written only when a push survives
    always_ff @(posedge clk) begin
        if (push && !flush) slots[wr_ptr[DEPTH_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC generation, I-cache, BHT prediction and instruction queue feeding the decoder
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int ICACHE_IDX_W = 8,
    parameter int BHT_IDX_W = 8,
    parameter int IQ_DEPTH_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mc_ready_in,
    input  logic [31:0]         mc_instruction_in,
    output logic                mc_request_out,
    output logic [31:0]         mc_address_out,
    input  logic                rs_full_in,
    input  logic                lsb_full_in,
    input  logic                rob_full_in,
    input  logic                rob_rollback_in,
    input  logic [31:0]         rob_rollback_pc_in,
    input  logic                rob_commit_signal_in,
    input  logic [31:0]         rob_commit_pc_in,
    input  logic                rob_branch_taken_in,
    output logic                dec_issue_out,
    output logic [31:0]         dec_inst_out,
    output logic [31:0]         dec_pc_out,
    output logic [31:0]         dec_predict_pc_out,
    output logic [IQ_DEPTH_W:0] iq_count_out
);

    localparam int CI_W = ICACHE_IDX_W > 0 ? ICACHE_IDX_W : 1;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    fetch_state_t state;
    fetch_state_t state_next;
    word_t pc;
    word_t inst;
    word_t pred;
    logic [6:0] opcode;
    logic push;
    logic pop;
    logic miss;
    logic fill;
    logic hit;
    logic full;
    logic empty;
    iq_entry_t entry_out;

    logic [2**CI_W-1:0] valid;
    logic [TAG_W-1:0] tags [2**CI_W];
    word_t lines [2**CI_W];
    logic [1:0] bht [2**BHT_IDX_W];

    logic [CI_W-1:0] cidx;
    logic [TAG_W-1:0] ctag;
    logic [BHT_IDX_W-1:0] bidx;
    logic [BHT_IDX_W-1:0] commit_idx;
    logic [1:0] commit_ctr;

    assign cidx = CI_W'(pc >> 2);
    assign ctag = TAG_W'(pc >> (ICACHE_IDX_W + 2));
    assign bidx = BHT_IDX_W'(pc >> 2);
    assign commit_idx = BHT_IDX_W'(rob_commit_pc_in >> 2);
    assign commit_ctr = bht[commit_idx];
    assign hit = (ICACHE_IDX_W != 0) && valid[cidx] && tags[cidx] == ctag;

    // fetch datapath, prediction and next fetch state; rollback overrides everything
    always_comb begin
        inst = state == WAITING ? mc_instruction_in : lines[cidx];
        opcode = inst[6:0];
        pred = opcode == JAL_OPCODE ? pc + imm_j(inst)
             : opcode == BRANCH_OPCODE && bht[bidx][1] ? pc + imm_b(inst) : pc + 32'd4;
        push = !rob_rollback_in && (state == IDLE ? !full && hit : state == WAITING && mc_ready_in);
        miss = !rob_rollback_in && state == IDLE && !full && !hit;
        fill = push && state == WAITING;
        pop = !empty && !rs_full_in && !lsb_full_in && !rob_full_in && !rob_rollback_in;
        state_next = rob_rollback_in ? (state != IDLE && !mc_ready_in ? DISCARD : IDLE)
                   : state == IDLE ? (miss ? WAITING : IDLE)
                   : mc_ready_in ? IDLE : state;
    end

    // fetch state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end

    // pc follows the prediction on each push; the request address is held between requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            mc_request_out <= 1'b0;
            mc_address_out <= '0;
        end else begin
            pc <= rob_rollback_in ? rob_rollback_pc_in : push ? pred : pc;
            mc_request_out <= miss;
            if (miss) mc_address_out <= pc;
        end
    end

    // cache valid bits and saturating branch counters; commits apply even during rollback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= 2'b10;
        end else begin
            if (fill) valid[cidx] <= 1'b1;
            if (rob_commit_signal_in)
                bht[commit_idx] <= rob_branch_taken_in ? commit_ctr + {1'b0, commit_ctr != 2'b11}
                                                       : commit_ctr - {1'b0, commit_ctr != 2'b00};
        end
    end

    // cache line data and tags, written on every miss fill
    always_ff @(posedge clk) begin
        if (fill) begin
            lines[cidx] <= mc_instruction_in;
            tags[cidx] <= ctag;
        end
    end

    // issue register: one pulse per pop, data held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_issue_out <= 1'b0;
            dec_inst_out <= '0;
            dec_pc_out <= '0;
            dec_predict_pc_out <= '0;
        end else begin
            dec_issue_out <= pop;
            if (pop) {dec_inst_out, dec_pc_out, dec_predict_pc_out} <= entry_out;
        end
    end

    fetch_inst_queue #(
        .DEPTH_W(IQ_DEPTH_W),
        .DATA_W($bits(iq_entry_t))
    ) queue (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .flush(rob_rollback_in),
        .push_data(iq_entry_t'{inst, pc, pred}),
        .head(entry_out),
        .full(full),
        .empty(empty),
        .count(iq_count_out)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed scenarios plus randomized stall/rollback run against a program-level model
module tb_fetch_queue_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mc_ready_in = 1'b0;
    logic [31:0] mc_instruction_in = '0;
    logic mc_request_out;
    logic [31:0] mc_address_out;
    logic rs_full_in = 1'b0;
    logic lsb_full_in = 1'b0;
    logic rob_full_in = 1'b0;
    logic rob_rollback_in = 1'b0;
    logic [31:0] rob_rollback_pc_in = '0;
    logic rob_commit_signal_in = 1'b0;
    logic [31:0] rob_commit_pc_in = '0;
    logic rob_branch_taken_in = 1'b0;
    logic dec_issue_out;
    logic [31:0] dec_inst_out;
    logic [31:0] dec_pc_out;
    logic [31:0] dec_predict_pc_out;
    logic [3:0] iq_count_out;

    fetch_queue_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .mc_ready_in(mc_ready_in),
        .mc_instruction_in(mc_instruction_in),
        .mc_request_out(mc_request_out),
        .mc_address_out(mc_address_out),
        .rs_full_in(rs_full_in),
        .lsb_full_in(lsb_full_in),
        .rob_full_in(rob_full_in),
        .rob_rollback_in(rob_rollback_in),
        .rob_rollback_pc_in(rob_rollback_pc_in),
        .rob_commit_signal_in(rob_commit_signal_in),
        .rob_commit_pc_in(rob_commit_pc_in),
        .rob_branch_taken_in(rob_branch_taken_in),
        .dec_issue_out(dec_issue_out),
        .dec_inst_out(dec_inst_out),
        .dec_pc_out(dec_pc_out),
        .dec_predict_pc_out(dec_predict_pc_out),
        .iq_count_out(iq_count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pred;
        int at;
    } iss_t;

    int passed = 0;
    int failed = 0;
    int total = 0;
    int cyc = 0;
    iss_t iss_q[$];
    logic [31:0] req_q[$];
    logic [31:0] prog [logic [31:0]];
    bit straight = 0;
    bit rnd_lat = 0;
    bit busy = 0;
    int lat = 0;
    int cnt = 0;
    logic [31:0] maddr = '0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hsh(logic [31:0] a);
        logic [31:0] h = a * 32'h9E3779B1;
        return h ^ (h >> 15);
    endfunction

    function automatic logic [2:0] kind(logic [31:0] a);
        logic [31:0] h = hsh(a);
        return h[18:16];
    endfunction

    function automatic logic [31:0] offs(logic [31:0] a);
        logic [31:0] h = hsh(a);
        logic [31:0] o = ({27'b0, h[24:20]} - 32'd16) << 2;
        return o == 0 ? 32'd8 : o;
    endfunction

    function automatic logic [31:0] enc_jal(logic [31:0] o);
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_beq(logic [31:0] o);
        return {o[12], o[10:5], 5'd0, 5'd0, 3'd0, o[4:1], o[11], 7'h63};
    endfunction

    // program image: explicit words first, then all-addi or a hashed mix of addi/jal/beq
    function automatic logic [31:0] mem_word(logic [31:0] a);
        logic [31:0] h = hsh(a);
        if (prog.exists(a)) return prog[a];
        if (straight) return 32'h00000013;
        return kind(a) == 6 ? enc_jal(offs(a)) : kind(a) == 7 ? enc_beq(offs(a)) : {h[31:20], 20'h00013};
    endfunction

    // untrained counters predict taken, so jumps and branches both go to pc+offset
    function automatic logic [31:0] ref_pred(logic [31:0] a);
        return kind(a) >= 6 ? a + offs(a) : a + 32'd4;
    endfunction

    task automatic tick();
        iss_t e;
        @(negedge clk);
        cyc++;
        if (dec_issue_out) begin
            e.pc = dec_pc_out;
            e.inst = dec_inst_out;
            e.pred = dec_predict_pc_out;
            e.at = cyc;
            iss_q.push_back(e);
        end
        if (mc_ready_in) begin
            mc_ready_in = 1'b0;
            busy = 0;
        end
        if (mc_request_out) begin
            chk("one_outstanding", {31'b0, busy}, 32'd0);
            busy = 1;
            maddr = mc_address_out;
            cnt = rnd_lat ? int'($urandom_range(0, 3)) : lat;
            req_q.push_back(maddr);
        end
        if (busy && !mc_ready_in) begin
            if (cnt == 0) begin
                mc_ready_in = 1'b1;
                mc_instruction_in = mem_word(maddr);
            end else cnt--;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {rs_full_in, lsb_full_in, rob_full_in, rob_rollback_in, rob_commit_signal_in, rob_branch_taken_in} = '0;
        mc_ready_in = 1'b0;
        busy = 0;
        tick();
        tick();
        iss_q.delete();
        req_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic rollback(logic [31:0] target);
        rob_rollback_in = 1'b1;
        rob_rollback_pc_in = target;
        tick();
        rob_rollback_in = 1'b0;
    endtask

    task automatic wait_issue(int n, int budget, string tag);
        int k = 0;
        while (iss_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, {31'b0, iss_q.size() >= n}, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] target;
        bit rb;
        int n;
        int k;
        iss_t e;

        // reset values, first miss, then a loop that must be served from the cache
        prog[32'h0] = 32'h00000013;
        prog[32'h4] = enc_jal(32'hFFFFFFFC);
        lat = 2;
        do_reset();
        chk("rst_issue", {31'b0, dec_issue_out}, 32'd0);
        chk("rst_req", {31'b0, mc_request_out}, 32'd0);
        chk("rst_addr", mc_address_out, 32'd0);
        chk("rst_count", {28'b0, iq_count_out}, 32'd0);
        chk("rst_pc", dec_pc_out, 32'd0);
        wait_issue(3, 60, "t1");
        chk("t1_pc0", iss_q[0].pc, 32'h0);
        chk("t1_inst0", iss_q[0].inst, 32'h00000013);
        chk("t1_pred0", iss_q[0].pred, 32'h4);
        chk("t1_pc1", iss_q[1].pc, 32'h4);
        chk("t1_pred1", iss_q[1].pred, 32'h0);
        chk("t1_pc2", iss_q[2].pc, 32'h0);
        repeat (10) tick();
        chk("t1_req_count", req_q.size(), 32'd2);
        chk("t1_req0", req_q[0], 32'h0);
        chk("t1_req1", req_q[1], 32'h4);

        // issue stalled: queue fills to 8 and fetch holds, then drains in order back to back
        prog.delete();
        straight = 1;
        lat = 0;
        do_reset();
        rob_full_in = 1'b1;
        repeat (20) tick();
        chk("t2_count", {28'b0, iq_count_out}, 32'd8);
        chk("t2_reqs", req_q.size(), 32'd8);
        repeat (3) tick();
        chk("t2_hold_reqs", req_q.size(), 32'd8);
        chk("t2_no_issue", iss_q.size(), 32'd0);
        rob_full_in = 1'b0;
        wait_issue(8, 20, "t2");
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", iss_q[i].pc, 32'(i * 4));
            chk("t2_b2b", iss_q[i].at, iss_q[0].at + i);
        end

        // backward branch predicted taken, then trained not-taken
        prog.delete();
        prog[32'h100] = 32'hFE000EE3;
        lat = 1;
        do_reset();
        rollback(32'h100);
        wait_issue(2, 40, "t3");
        chk("t3_pc", iss_q[0].pc, 32'h100);
        chk("t3_inst", iss_q[0].inst, 32'hFE000EE3);
        chk("t3_pred_taken", iss_q[0].pred, 32'hFC);
        chk("t3_pc1", iss_q[1].pc, 32'hFC);
        chk("t3_pred1", iss_q[1].pred, 32'h100);
        rob_commit_signal_in = 1'b1;
        rob_commit_pc_in = 32'h100;
        rob_branch_taken_in = 1'b0;
        tick();
        tick();
        rob_commit_signal_in = 1'b0;
        rollback(32'h100);
        chk("t3_rb_issue", {31'b0, dec_issue_out}, 32'd0);
        iss_q.delete();
        wait_issue(1, 40, "t3b");
        chk("t3_pc_nt", iss_q[0].pc, 32'h100);
        chk("t3_pred_nt", iss_q[0].pred, 32'h104);

        // jal prediction steers the next fetch address
        prog.delete();
        prog[32'h20] = 32'h0080006F;
        do_reset();
        rollback(32'h20);
        wait_issue(2, 40, "t4");
        chk("t4_pred", iss_q[0].pred, 32'h28);
        chk("t4_req0", req_q[0], 32'h20);
        chk("t4_req1", req_q[1], 32'h28);
        chk("t4_pc1", iss_q[1].pc, 32'h28);

        // rollback while a miss is outstanding: returned word is dropped and not cached
        prog.delete();
        lat = 2;
        do_reset();
        tick();
        rollback(32'h400);
        chk("t5_rb_issue", {31'b0, dec_issue_out}, 32'd0);
        chk("t5_rb_count", {28'b0, iq_count_out}, 32'd0);
        wait_issue(1, 40, "t5");
        chk("t5_pc", iss_q[0].pc, 32'h400);
        chk("t5_req", req_q[1], 32'h400);
        rollback(32'h0);
        n = req_q.size();
        k = 0;
        while (req_q.size() <= n && k < 40) begin
            tick();
            k++;
        end
        chk("t5_refetch_timeout", {31'b0, req_q.size() > n}, 32'd1);
        chk("t5_no_fill", req_q[n], 32'h0);

        // rollback flushes a partly full queue while a same-cycle commit still trains the BHT
        prog.delete();
        prog[32'h100] = 32'hFE000EE3;
        lat = 0;
        do_reset();
        rob_full_in = 1'b1;
        k = 0;
        while (iq_count_out != 4'd5 && k < 40) begin
            tick();
            k++;
        end
        chk("t6_count5", {28'b0, iq_count_out}, 32'd5);
        rob_full_in = 1'b0;
        rob_commit_signal_in = 1'b1;
        rob_commit_pc_in = 32'h100;
        rob_branch_taken_in = 1'b0;
        rollback(32'h100);
        rob_commit_signal_in = 1'b0;
        chk("t6_flushed", {28'b0, iq_count_out}, 32'd0);
        chk("t6_no_issue", {31'b0, dec_issue_out}, 32'd0);
        iss_q.delete();
        wait_issue(1, 40, "t6");
        chk("t6_pc", iss_q[0].pc, 32'h100);
        chk("t6_pred_nt", iss_q[0].pred, 32'h104);

        // random stalls, memory latency and rollbacks over a hashed program
        prog.delete();
        straight = 0;
        rnd_lat = 1;
        do_reset();
        exp_pc = 32'h0;
        for (int i = 0; i < 4000; i++) begin
            rs_full_in = $urandom_range(0, 9) == 0;
            lsb_full_in = $urandom_range(0, 9) == 0;
            rob_full_in = $urandom_range(0, 6) == 0;
            rb = $urandom_range(0, 49) == 0;
            target = $urandom_range(0, 1023) << 2;
            rob_rollback_in = rb;
            rob_rollback_pc_in = target;
            tick();
            while (iss_q.size() > 0) begin
                e = iss_q.pop_front();
                chk("rnd_pc", e.pc, exp_pc);
                chk("rnd_inst", e.inst, mem_word(exp_pc));
                chk("rnd_pred", e.pred, ref_pred(exp_pc));
                exp_pc = ref_pred(exp_pc);
            end
            if (rb) begin
                chk("rnd_rb_issue", {31'b0, dec_issue_out}, 32'd0);
                chk("rnd_rb_count", {28'b0, iq_count_out}, 32'd0);
                exp_pc = target;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
